mul_sequencer: RTL
==================

# mul_sequencer

Multi-cycle 32-bit integer multiplier (RV32M MUL, low 32 bits of product) that contains no adder or shifter of its own. It computes the product by shift-and-add, sequencing the core's shared `alu` for both the add and the left-shift. It sits beside the EX stage, takes a request over a valid/ready handshake, and claims the ALU via `alu_own` while busy. The top level muxes the ALU inputs on `alu_own`.

## Interface
- `ITER_MAX`, default 32: maximum shift-add iterations; equals the operand width.
- `clk`  in  1  — single clock; all state changes on rising edge.
- `rst_n`  in  1  — reset, synchronous, active-low.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — block can accept; high only in IDLE.
- `req_a`  in  32  — multiplicand.
- `req_b`  in  32  — multiplier.
- `resp_valid`  out  1  — product available; high only in DONE.
- `resp_ready`  in  1  — consumer takes product.
- `resp_data`  out  32  — product[31:0].
- `alu_own`  out  1  — ALU claimed; high only in ADD and SHIFT.
- `alu_src1`  out  32  — ALU operand 1.
- `alu_src2`  out  32  — ALU operand 2.
- `alu_ctrl`  out  4  — ALU opcode (0010 ADD, 0100 SLL).
- `alu_result`  in  32  — ALU result, combinational from `alu_*` outputs.

## Operation
- Internal registers: `acc` (32), `mcand` (32), `mplier` (32), `cnt` (6), `state` (2 bits).
- States: IDLE, ADD, SHIFT, DONE.
- IDLE
  - `req_ready`=1.
  - On `req_valid`: load `acc`=0, `mcand`=`req_a`, `mplier`=`req_b`, `cnt`=0.
  - Next state is ADD if `req_b`≠0, else DONE.
- ADD
  - Drive `alu_src1`=`acc`, `alu_src2`=`mcand`, `alu_ctrl`=0010.
  - If `mplier[0]`=1, `acc`←`alu_result`; otherwise `acc` holds.
  - Next state SHIFT.
- SHIFT
  - Drive `alu_src1`=`mcand`, `alu_src2`=1, `alu_ctrl`=0100.
  - Update `mcand`←`alu_result`, `mplier`←`mplier`>>1 (logical), `cnt`←`cnt`+1.
  - Next state DONE if (`mplier`>>1)==0 or `cnt`+1==`ITER_MAX`; else ADD.
- DONE
  - `resp_valid`=1, `resp_data`=`acc`.
  - Go to IDLE when `resp_ready`=1.
  - `acc` holds until the next accept.
- Outside ADD/SHIFT, drive `alu_src1`=0, `alu_src2`=0, `alu_ctrl`=0000.
- Arithmetic wraps mod 2^32. Signed and unsigned MUL give identical low-word results, so no sign handling is done.
- A negative multiplier always runs all `ITER_MAX` iterations.
- Reset (`rst_n`=0 at a rising edge), mid-operation included:
  - State → IDLE; `acc`, `mcand`, `mplier`, `cnt` → 0.
  - Any in-flight product is discarded silently.
- Reset output values: `req_ready`=1, `resp_valid`=0, `resp_data`=0, `alu_own`=0, `alu_src1`=0, `alu_src2`=0, `alu_ctrl`=0000.
- The ALU itself must be held out of reset while `alu_own`=1. Its reset forces the result to 0.

## Timing
- All outputs are decoded combinationally from `state` and registers; there are no input-to-output combinational paths except through `alu_result`.
- Accept edge E0: the rising edge where `req_valid`&&`req_ready`.
- Latency:
  - Let N = index of the highest set bit of `req_b` + 1 (N=0 for zero; N=32 if bit 31 set).
  - `resp_valid` first high after edge E0+2N.
  - N=0 → `resp_valid` high after E0 itself.
- Each iteration is exactly 2 cycles (ADD, SHIFT). ADD is spent even when `mplier[0]`=0.
- Response hold: `resp_valid`/`resp_data` stay stable while `resp_ready`=0, for any number of cycles.
- Throughput: `req_ready` returns the cycle after the response handshake edge. Accepting in the same cycle as the response handshake is not supported.
- `req_valid` while busy is ignored. The requester must hold it until `req_ready`.

## Test plan
- Basic multiply: reset, then `req_a`=3, `req_b`=5 → `alu_own` high for 6 cycles; `resp_valid` after E0+6; `resp_data`=15.
- Zero multiplier: `req_a`=0x12345678, `req_b`=0 → `resp_valid` after E0; `resp_data`=0; `alu_own` never asserted.
- Full-length and wrap:
  - `req_a`=0xFFFFFFFF, `req_b`=0xFFFFFFFF → 32 iterations; `resp_valid` after E0+64; `resp_data`=0x00000001.
  - `req_a`=0x80000000, `req_b`=2 → `resp_data`=0.
- Backpressure: `resp_ready`=0 for 10 cycles after `resp_valid` → data and valid hold; `req_ready`=0 throughout; IDLE one edge after `resp_ready`=1.
- Reset mid-operation: `rst_n`=0 for one edge during the SHIFT of iteration 3 → next cycle `req_ready`=1, `resp_valid`=0, `alu_own`=0, all `alu_*`=0; a new 7×6 request then yields 42.
- Back-to-back random: 200 random (a,b) pairs with random `resp_ready` stalls → `resp_data`==(a*b)[31:0]; latency==2N for every pair.

Source files
------------

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: request/response handshake plus shared-ALU borrow port of the multiplier.
interface mul_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        alu_own;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    modport master (
        output req_valid, req_a, req_b, resp_ready, alu_result,
        input  req_ready, resp_valid, resp_data, alu_own, alu_src1, alu_src2, alu_ctrl
    );
    modport slave (
        input  req_valid, req_a, req_b, resp_ready, alu_result,
        output req_ready, resp_valid, resp_data, alu_own, alu_src1, alu_src2, alu_ctrl
    );
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-and-add 32-bit MUL (low word) that borrows the core ALU for every add and shift.
module mul_sequencer #(
    parameter int ITER_MAX = 32
) (
    input logic            clk,
    input logic            rst_n,
    mul_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [5:0] ITER_LAST = 6'(ITER_MAX - 1);

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [5:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Stop as soon as no multiplier bits remain, so latency tracks the highest set bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !bus.req_valid ? IDLE : (bus.req_b != '0 ? ADD : DONE);
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = (mplier_q[31:1] == '0 || cnt_q == ITER_LAST) ? DONE : ADD;
            default: state_d = bus.resp_ready ? IDLE : DONE;
        endcase
    end

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (state_q == IDLE && bus.req_valid) begin
            acc_d    = '0;
            mcand_d  = bus.req_a;
            mplier_d = bus.req_b;
            cnt_d    = '0;
        end
        if (state_q == ADD && mplier_q[0])
            acc_d = bus.alu_result;
        if (state_q == SHIFT) begin
            mcand_d  = bus.alu_result;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 6'd1;
        end
    end

    always_comb begin
        bus.req_ready  = state_q == IDLE;
        bus.resp_valid = state_q == DONE;
        bus.resp_data  = state_q == DONE ? acc_q : '0;
        bus.alu_own    = state_q == ADD || state_q == SHIFT;
        bus.alu_src1   = state_q == ADD ? acc_q : (state_q == SHIFT ? mcand_q : '0);
        bus.alu_src2   = state_q == ADD ? mcand_q : (state_q == SHIFT ? 32'd1 : '0);
        bus.alu_ctrl   = state_q == ADD ? ALU_ADD : (state_q == SHIFT ? ALU_SLL : 4'b0000);
    end
endmodule
